multisymbolsum_sched: RTL and testbench

MULTISYMBOLSUM_SCHED -- requirements
Module: multisymbolsum_sched

---
 rtl/multisymbolsum_sched.sv | 112 +++++++++++
 tb/tb_multisymbolsum_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multisymbolsum_sched.sv
// Credit-based scheduler for a shared multi-symbol adder tree: round-robin issue, fixed-latency
// tracking, result-buffer pointers. Optional counters under MULTISYMBOLSUM_SCHED_STATS_EN.
module multisymbolsum_sched #(
  parameter int SUM_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TAG_W       = 4,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [1:0]            req_ready,
  output logic                  issue_valid,
  output logic                  issue_sel,
  output logic                  buf_wr_en,
  output logic [AW-1:0]         buf_wr_addr,
  output logic [AW-1:0]         buf_rd_addr,
  output logic                  res_valid,
  output logic                  res_src,
  output logic [TAG_W-1:0]      res_tag,
  input  logic                  res_ready
`ifdef MULTISYMBOLSUM_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stalled
`endif
);

  logic [AW:0]            used;      // operations in flight plus buffered entries
  logic [AW:0]            occ;       // buffered entries only
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   prio;
  logic [SUM_LATENCY-1:0] pipe_v;
  logic [SUM_LATENCY-1:0] pipe_src;
  logic [TAG_W-1:0]       pipe_tag [SUM_LATENCY];
  logic                   src_mem  [FIFO_DEPTH];
  logic [TAG_W-1:0]       tag_mem  [FIFO_DEPTH];

  logic credit_ok;
  logic winner;
  logic grant;
  logic rd_fire;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    credit_ok = used < (AW+1)'(FIFO_DEPTH);
    winner    = prio;
    if (req_valid == 2'b01)      winner = 1'b0;
    else if (req_valid == 2'b10) winner = 1'b1;
    grant       = !reset && credit_ok && (req_valid != 2'b00);
    req_ready   = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
    issue_valid = grant;
    issue_sel   = winner;
    buf_wr_en   = pipe_v[SUM_LATENCY-1] && !reset;
    buf_wr_addr = wr_ptr;
    buf_rd_addr = rd_ptr;
    res_valid   = (occ != '0) && !reset;
    res_src     = res_valid ? src_mem[rd_ptr] : 1'b0;
    res_tag     = res_valid ? tag_mem[rd_ptr] : '0;
    rd_fire     = res_valid && res_ready;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      used   <= '0;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      prio   <= 1'b0;
      pipe_v <= '0;
    end else begin
      used <= used + (AW+1)'(grant) - (AW+1)'(rd_fire);
      occ  <= occ + (AW+1)'(buf_wr_en) - (AW+1)'(rd_fire);
      if (buf_wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire)   rd_ptr <= rd_ptr + 1'b1;
      if (grant)     prio   <= !winner;
      pipe_v[0] <= grant;
      for (int i = 1; i < SUM_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // NOTE: payload storage has no reset; it is only ever observed behind a reset-cleared valid.
  always_ff @(posedge clk) begin
    pipe_src[0] <= winner;
    pipe_tag[0] <= req_tag[winner];
    for (int i = 1; i < SUM_LATENCY; i++) begin
      pipe_src[i] <= pipe_src[i-1];
      pipe_tag[i] <= pipe_tag[i-1];
    end
    if (buf_wr_en) begin
      src_mem[wr_ptr] <= pipe_src[SUM_LATENCY-1];
      tag_mem[wr_ptr] <= pipe_tag[SUM_LATENCY-1];
    end
  end

`ifdef MULTISYMBOLSUM_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued  <= '0;
      stat_stalled <= '0;
    end else begin
      if (grant && stat_issued != '1) stat_issued <= stat_issued + 32'd1;
      if ((req_valid != 2'b00) && !credit_ok && stat_stalled != '1)
        stat_stalled <= stat_stalled + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multisymbolsum_sched.sv
// Scoreboard bench for multisymbolsum_sched: driver predicts grants and queues expected results,
// a separate monitor checks buffer writes and result handshakes.
module tb_multisymbolsum_sched;
  localparam int L  = 4;
  localparam int D  = 8;
  localparam int TW = 4;
  localparam int AW = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         req_valid = 2'b00;
  logic [1:0][TW-1:0] req_tag = '0;
  logic               res_ready = 1'b0;
  logic [1:0]         req_ready;
  logic               issue_valid, issue_sel, buf_wr_en, res_valid, res_src;
  logic [AW-1:0]      buf_wr_addr, buf_rd_addr;
  logic [TW-1:0]      res_tag;
`ifdef MULTISYMBOLSUM_SCHED_STATS_EN
  logic [31:0]        stat_issued, stat_stalled;
`endif

  always #5 clk = ~clk;

  multisymbolsum_sched #(.SUM_LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_sel(issue_sel), .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr), .buf_rd_addr(buf_rd_addr), .res_valid(res_valid),
    .res_src(res_src), .res_tag(res_tag), .res_ready(res_ready)
`ifdef MULTISYMBOLSUM_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stalled(stat_stalled)
`endif
  );

  typedef struct packed {
    logic          src;
    logic [TW-1:0] tag;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   lat_q[$];

  int         m_used = 0, m_occ = 0, m_issued = 0, m_stalled = 0, grants = 0;
  logic       m_prio = 1'b0;
  logic [L-1:0] m_pipe = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the bench's own scheduling model predicts the handshake outcome.
  task automatic step(input logic [1:0] v, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                      input logic rr);
    logic credit, win, grant, rd;
    logic [1:0] exp_rdy;
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = v;
    req_tag[0] = t0;
    req_tag[1] = t1;
    res_ready = rr;
    @(negedge clk);
    credit  = m_used < D;
    win     = (v == 2'b11) ? m_prio : (v == 2'b10);
    grant   = credit && (v != 2'b00);
    exp_rdy = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("issue_valid", 32'(issue_valid), 32'(grant));
    if (grant) check("issue_sel", 32'(issue_sel), 32'(win));
    check("buf_wr_en", 32'(buf_wr_en), 32'(m_pipe[L-1]));
    check("res_valid", 32'(res_valid), 32'(m_occ > 0));
    rd = (m_occ > 0) && rr;
    if (grant) begin
      e.src = win;
      e.tag = win ? t1 : t0;
      sb.push_back(e);
      lat_q.push_back(cyc);
      m_prio = !win;
      grants++;
      m_issued++;
    end
    if (v != 2'b00 && !credit) m_stalled++;
    m_occ  = m_occ + int'(m_pipe[L-1]) - int'(rd);
    m_used = m_used + int'(grant) - int'(rd);
    m_pipe = {m_pipe[L-2:0], grant};
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 2'b00;
    res_ready = 1'b0;
    sb.delete();
    lat_q.delete();
    m_used = 0; m_occ = 0; m_pipe = '0; m_prio = 1'b0; m_issued = 0; m_stalled = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_issue_valid", 32'(issue_valid), 32'd0);
      check("rst_buf_wr_en", 32'(buf_wr_en), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_src", 32'(res_src), 32'd0);
      check("rst_res_tag", 32'(res_tag), 32'd0);
      if (i > 0) begin
        check("rst_wr_addr", 32'(buf_wr_addr), 32'd0);
        check("rst_rd_addr", 32'(buf_rd_addr), 32'd0);
      end
    end
  endtask

  // Monitor: buffer write address/latency, result order and head stability under backpressure.
  int            mon_wr = 0, mon_rd = 0;
  logic          prev_hold = 1'b0;
  logic          prev_src = 1'b0;
  logic [TW-1:0] prev_tag = '0;
  exp_t          got;

  always @(negedge clk) begin
    if (reset) begin
      mon_wr = 0;
      mon_rd = 0;
      prev_hold = 1'b0;
    end else begin
      if (buf_wr_en) begin
        check("wr_addr", 32'(buf_wr_addr), 32'(mon_wr));
        mon_wr = (mon_wr + 1) % D;
        if (lat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: write with no issue outstanding (cycle %0d)", cyc);
        end else begin
          check("wr_latency", 32'(cyc - lat_q.pop_front()), 32'(L));
        end
      end
      if (prev_hold && res_valid) begin
        check("hold_src", 32'(res_src), 32'(prev_src));
        check("hold_tag", 32'(res_tag), 32'(prev_tag));
      end
      if (res_valid && res_ready) begin
        check("rd_addr", 32'(buf_rd_addr), 32'(mon_rd));
        mon_rd = (mon_rd + 1) % D;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected: result with empty scoreboard (cycle %0d)", cyc);
        end else begin
          got = sb.pop_front();
          check("res_src", 32'(res_src), 32'(got.src));
          check("res_tag", 32'(res_tag), 32'(got.tag));
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_src  = res_src;
      prev_tag  = res_tag;
    end
  end

  initial begin
    do_reset(2);

    // Single request on requester 0, tag 3: write at addr 0 four cycles later, then result.
    step(2'b01, 4'd3, 4'd0, 1'b1);
    repeat (8) step(2'b00, 4'd0, 4'd0, 1'b1);

    // Both requesters continuously: alternating grants, one issue per cycle, in-order results.
    for (int i = 0; i < 12; i++) step(2'b11, 4'(i), 4'(15 - i), 1'b1);
    repeat (8) step(2'b00, 4'd0, 4'd0, 1'b1);

    // Full backpressure: exactly eight issues, then one more after a single read.
    grants = 0;
    for (int i = 0; i < 14; i++) step(2'b01, 4'(i), 4'd0, 1'b0);
    check("fill_grants", 32'(grants), 32'd8);
    grants = 0;
    step(2'b01, 4'd14, 4'd0, 1'b1);
    step(2'b01, 4'd15, 4'd0, 1'b0);
    repeat (4) step(2'b01, 4'd1, 4'd0, 1'b0);
    check("pulse_grants", 32'(grants), 32'd1);

    // Drain while issuing: pointers wrap, tags stay ordered.
    for (int i = 0; i < 20; i++) step(2'b11, 4'(i + 3), 4'(i + 9), 1'b1);
    repeat (10) step(2'b00, 4'd0, 4'd0, 1'b1);

    // Reset with three in flight and two buffered; everything is discarded.
    for (int i = 0; i < 5; i++) step(2'b01, 4'(i + 5), 4'd0, 1'b0);
    step(2'b00, 4'd0, 4'd0, 1'b0);
    do_reset(2);
    step(2'b10, 4'd0, 4'd10, 1'b1);
    repeat (3) step(2'b00, 4'd0, 4'd0, 1'b1);
    check("post_rst_wr_addr", 32'(buf_wr_addr), 32'd0);
    repeat (5) step(2'b00, 4'd0, 4'd0, 1'b1);

    // Mixed requesters under intermittent backpressure.
    for (int i = 0; i < 30; i++)
      step((i % 4 == 0) ? 2'b10 : 2'b11, 4'(i), 4'(i + 7), (i % 3) != 0);
    repeat (16) step(2'b00, 4'd0, 4'd0, 1'b1);
    check("sb_empty", 32'(sb.size()), 32'd0);

`ifdef MULTISYMBOLSUM_SCHED_STATS_EN
    check("stat_issued", stat_issued, 32'(m_issued));
    check("stat_stalled", stat_stalled, 32'(m_stalled));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
